usb_rx_line_monitor: RTL and testbench

Full-speed USB receive line monitor running at 48 MHz, four samples per bit. It sits directly upstream of the RX timeout counter. It filters the synchronized D+/D− pins into a line state and detects end-of-packet, start of bus activity and bus reset. Its `rxGotSignal_o` pulse drives the timeout block's got-signal input, and its `eop_o` pulse marks the SE0-to-J point from which the inter-packet timeout is measured.

---
 rtl/usb_rx_pkg.sv | 22 ++
 rtl/usb_rx_line_monitor_if.sv | 23 ++
 rtl/usb_line_filter.sv | 30 +++
 rtl/usb_rx_line_monitor.sv | 114 +++++++++++
 tb/tb_usb_rx_line_monitor.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and default timing constants for the full-speed USB receive line monitor.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  localparam int unsigned EOP_MIN_TICKS_DEF = 4;
  localparam int unsigned EOP_MAX_TICKS_DEF = 12;
  localparam int unsigned RESET_TICKS_DEF   = 120;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_SE0,
    ST_RESET
  } line_mon_state_t;

endpackage

// File: rtl/usb_rx_line_monitor_if.sv
// Pin inputs and event outputs of the USB receive line monitor.
interface usb_rx_line_monitor_if;
  import usb_rx_pkg::*;

  logic        dataInP_i;
  logic        dataInN_i;
  line_state_t lineState_o;
  logic        rxGotSignal_o;
  logic        eop_o;
  logic        eopError_o;
  logic        usbReset_o;

  modport master (
    output dataInP_i, dataInN_i,
    input  lineState_o, rxGotSignal_o, eop_o, eopError_o, usbReset_o
  );

  modport slave (
    input  dataInP_i, dataInN_i,
    output lineState_o, rxGotSignal_o, eop_o, eopError_o, usbReset_o
  );

endinterface

// File: rtl/usb_line_filter.sv
// Two-sample stability filter: a pin pair is accepted only once seen on two consecutive edges.
module usb_line_filter
  import usb_rx_pkg::*;
(
  input  logic        clk48_i,
  input  logic        rstn_i,
  input  logic        dataInP_i,
  input  logic        dataInN_i,
  output line_state_t lineState_o
);

  line_state_t raw;
  line_state_t raw_q;

  assign raw = line_state_t'({dataInP_i, dataInN_i});

  // SE1 is illegal on the bus, so it never replaces the held state.
  always_ff @(posedge clk48_i or negedge rstn_i) begin
    if (!rstn_i) begin
      raw_q       <= LS_J;
      lineState_o <= LS_J;
    end else begin
      raw_q <= raw;
      if ((raw == raw_q) && (raw != LS_SE1)) begin
        lineState_o <= raw;
      end
    end
  end

endmodule

// File: rtl/usb_rx_line_monitor.sv
// Full-speed USB RX line monitor: filtered line state, EOP / bus-activity / bus-reset detection.
module usb_rx_line_monitor
  import usb_rx_pkg::*;
#(
  parameter int unsigned EOP_MIN_TICKS = EOP_MIN_TICKS_DEF,
  parameter int unsigned EOP_MAX_TICKS = EOP_MAX_TICKS_DEF,
  parameter int unsigned RESET_TICKS   = RESET_TICKS_DEF
) (
  input logic                  clk48_i,
  input logic                  rstn_i,
  usb_rx_line_monitor_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(RESET_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(EOP_MIN_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EOP_MAX_TICKS);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(RESET_TICKS);

  line_state_t      line_state;
  logic [CNT_W-1:0] se0_cnt;

  line_mon_state_t  state, state_nxt;
  logic             got_q, eop_q, err_q, usb_reset_q;
  logic             got_nxt, eop_nxt, err_nxt;

  usb_line_filter u_filter (
    .clk48_i     (clk48_i),
    .rstn_i      (rstn_i),
    .dataInP_i   (bus.dataInP_i),
    .dataInN_i   (bus.dataInN_i),
    .lineState_o (line_state)
  );

  // Length of the current filtered SE0, saturating at the bus-reset threshold.
  always_ff @(posedge clk48_i or negedge rstn_i) begin
    if (!rstn_i) begin
      se0_cnt <= '0;
    end else if (line_state != LS_SE0) begin
      se0_cnt <= '0;
    end else if (se0_cnt != CNT_RST) begin
      se0_cnt <= se0_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk48_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= ST_IDLE;
      got_q       <= 1'b0;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
      usb_reset_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      got_q       <= got_nxt;
      eop_q       <= eop_nxt;
      err_q       <= err_nxt;
      usb_reset_q <= (state_nxt == ST_RESET);
    end
  end

  always_comb begin
    state_nxt = state;
    got_nxt   = 1'b0;
    eop_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (line_state == LS_K) begin
          state_nxt = ST_ACTIVE;
          got_nxt   = 1'b1;
        end else if (line_state == LS_SE0) begin
          state_nxt = ST_SE0;
        end
      end
      ST_ACTIVE: begin
        if (line_state == LS_SE0) begin
          state_nxt = ST_SE0;
        end
      end
      ST_SE0: begin
        // Reaching the reset length wins over a J arriving in the same cycle.
        if (se0_cnt == CNT_RST) begin
          state_nxt = ST_RESET;
        end else if (line_state == LS_J) begin
          state_nxt = ST_IDLE;
          if ((se0_cnt >= CNT_MIN) && (se0_cnt <= CNT_MAX)) begin
            eop_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (line_state == LS_K) begin
          state_nxt = ST_ACTIVE;
          err_nxt   = 1'b1;
        end
      end
      ST_RESET: begin
        if (line_state == LS_J) begin
          state_nxt = ST_IDLE;
        end else if (line_state == LS_K) begin
          state_nxt = ST_ACTIVE;
          got_nxt   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.lineState_o   = line_state;
  assign bus.rxGotSignal_o = got_q;
  assign bus.eop_o         = eop_q;
  assign bus.eopError_o    = err_q;
  assign bus.usbReset_o    = usb_reset_q;

endmodule

// File: tb/tb_usb_rx_line_monitor.sv
// Self-checking bench for usb_rx_line_monitor: vector table, directed corner cases, random vs reference model.
module tb_usb_rx_line_monitor;
  import usb_rx_pkg::*;

  localparam logic [1:0] PJ  = 2'b10;
  localparam logic [1:0] PK  = 2'b01;
  localparam logic [1:0] P0  = 2'b00;
  localparam logic [1:0] P1  = 2'b11;
  localparam int         RST = 120;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  usb_rx_line_monitor_if bus ();

  usb_rx_line_monitor dut (
    .clk48_i (clk),
    .rstn_i  (rstn),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: tracks filtered line history and SE0 run length directly.
  logic [1:0] m_prev_p, m_ls_a, m_ls_b;
  int         m_run_b;
  bit         m_idle;
  logic [1:0] e_ls;
  logic       e_got, e_eop, e_err, e_rst;

  function automatic void model_init();
    m_prev_p = PJ; m_ls_a = PJ; m_ls_b = PJ; m_run_b = 0; m_idle = 1'b1;
    e_ls = PJ; e_got = 1'b0; e_eop = 1'b0; e_err = 1'b0; e_rst = 1'b0;
  endfunction

  function automatic void model_step(input logic [1:0] p);
    logic [1:0] ls_new;
    bit         se0_end;
    ls_new  = ((p == m_prev_p) && (p != P1)) ? p : m_ls_a;
    se0_end = (m_ls_b == P0) && (m_ls_a != P0);
    e_eop = se0_end && (m_ls_a == PJ) && (m_run_b < RST) && (m_run_b >= 4) && (m_run_b <= 12);
    e_err = se0_end && (m_run_b < RST) && !e_eop;
    e_got = (m_ls_a == PK) && (m_ls_b != PK) &&
            (((m_ls_b == PJ) && m_idle) || ((m_ls_b == P0) && (m_run_b >= RST)));
    e_rst = (m_run_b >= RST) && (m_ls_a == P0);
    if ((m_ls_b == P0) && (m_ls_a == PJ)) m_idle = 1'b1;
    if (m_ls_a == PK) m_idle = 1'b0;
    e_ls    = ls_new;
    m_run_b = (m_ls_a == P0) ? ((m_run_b + 1 > RST) ? RST : m_run_b + 1) : 0;
    m_ls_b  = m_ls_a;
    m_ls_a  = ls_new;
    m_prev_p = p;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("ls_model",  bus.lineState_o,   e_ls);
    check("got_model", bus.rxGotSignal_o, e_got);
    check("eop_model", bus.eop_o,         e_eop);
    check("err_model", bus.eopError_o,    e_err);
    check("rst_model", bus.usbReset_o,    e_rst);
    check("eop_err_excl", bus.eop_o & bus.eopError_o, 1'b0);
    check("got_eop_excl", bus.rxGotSignal_o & bus.eop_o, 1'b0);
  endtask

  // Drive one pin pair for one clock; outputs are sampled on the following falling edge.
  task automatic tick(input logic [1:0] p, input bit cmp);
    {bus.dataInP_i, bus.dataInN_i} = p;
    model_step(p);
    @(posedge clk);
    @(negedge clk);
    if (cmp) check_model();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    {bus.dataInP_i, bus.dataInN_i} = PJ;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_init();
  endtask

  typedef struct {
    logic [1:0] pins;
    logic [1:0] ls;
    logic       got, eop, err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [1:0] p, input logic [1:0] ls,
                              input logic got, input logic eop, input logic err);
    vec_t v;
    v.pins = p; v.ls = ls; v.got = got; v.eop = eop; v.err = err;
    tbl.push_back(v);
  endfunction

  initial begin
    int bnd_len[4];
    bit bnd_eop[4];
    int eop_seen;

    model_init();
    {bus.dataInP_i, bus.dataInN_i} = P0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

    // Reset held with pins at SE0: line reads J and nothing fires.
    check("rst_ls",  bus.lineState_o,   PJ);
    check("rst_got", bus.rxGotSignal_o, 1'b0);
    check("rst_eop", bus.eop_o,         1'b0);
    check("rst_err", bus.eopError_o,    1'b0);
    check("rst_usb", bus.usbReset_o,    1'b0);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) tick(P0, 1'b1);
    for (int i = 0; i < 5; i++)  tick(PJ, 1'b1);

    // Vector table: glitches, packet with 4-tick EOP, 3-tick SE0, SE0 into K.
    add(PJ, PJ, 0, 0, 0); add(PK, PJ, 0, 0, 0); add(PJ, PJ, 0, 0, 0); add(P1, PJ, 0, 0, 0);
    add(PJ, PJ, 0, 0, 0); add(PK, PJ, 0, 0, 0); add(PK, PK, 0, 0, 0); add(PK, PK, 1, 0, 0);
    add(PK, PK, 0, 0, 0); add(P0, PK, 0, 0, 0); add(P0, P0, 0, 0, 0); add(P0, P0, 0, 0, 0);
    add(P0, P0, 0, 0, 0); add(PJ, P0, 0, 0, 0); add(PJ, PJ, 0, 0, 0); add(PJ, PJ, 0, 1, 0);
    add(PJ, PJ, 0, 0, 0); add(P0, PJ, 0, 0, 0); add(P0, P0, 0, 0, 0); add(P0, P0, 0, 0, 0);
    add(PJ, P0, 0, 0, 0); add(PJ, PJ, 0, 0, 0); add(PJ, PJ, 0, 0, 1); add(PJ, PJ, 0, 0, 0);
    add(P0, PJ, 0, 0, 0); add(P0, P0, 0, 0, 0); add(PK, P0, 0, 0, 0); add(PK, PK, 0, 0, 0);
    add(PK, PK, 0, 0, 1); add(PK, PK, 0, 0, 0); add(PJ, PK, 0, 0, 0); add(PJ, PJ, 0, 0, 0);
    add(PJ, PJ, 0, 0, 0);
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].pins, 1'b0);
      check($sformatf("tbl%0d_ls", i),  bus.lineState_o,   tbl[i].ls);
      check($sformatf("tbl%0d_got", i), bus.rxGotSignal_o, tbl[i].got);
      check($sformatf("tbl%0d_eop", i), bus.eop_o,         tbl[i].eop);
      check($sformatf("tbl%0d_err", i), bus.eopError_o,    tbl[i].err);
      check($sformatf("tbl%0d_usb", i), bus.usbReset_o,    1'b0);
    end

    // EOP length bounds around the accepted window.
    bnd_len = '{3, 4, 12, 13};
    bnd_eop = '{0, 1, 1, 0};
    for (int b = 0; b < 4; b++) begin
      do_reset();
      for (int i = 0; i < 3; i++) tick(PJ, 1'b1);
      for (int i = 0; i < 6; i++) begin
        tick(PK, 1'b1);
        check($sformatf("bnd%0d_got%0d", bnd_len[b], i), bus.rxGotSignal_o, (i == 2) ? 1'b1 : 1'b0);
      end
      for (int i = 0; i < bnd_len[b]; i++) tick(P0, 1'b1);
      for (int i = 0; i < 5; i++) begin
        tick(PJ, 1'b1);
        if (i == 2) begin
          check($sformatf("bnd%0d_eop", bnd_len[b]), bus.eop_o,      bnd_eop[b]);
          check($sformatf("bnd%0d_err", bnd_len[b]), bus.eopError_o, !bnd_eop[b]);
        end
      end
    end

    // Bus reset: 200 SE0 cycles, then J, then K.
    do_reset();
    for (int i = 0; i < 3; i++) tick(PJ, 1'b1);
    for (int i = 0; i < 200; i++) begin
      tick(P0, 1'b1);
      if (i == 121) check("busrst_low_121",  bus.usbReset_o, 1'b0);
      if (i == 122) check("busrst_high_122", bus.usbReset_o, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      tick(PJ, 1'b1);
      check($sformatf("busrst_j%0d", i), bus.usbReset_o, (i < 2) ? 1'b1 : 1'b0);
      check($sformatf("busrst_eop%0d", i), bus.eop_o, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      tick(PK, 1'b1);
      check($sformatf("busrst_got%0d", i), bus.rxGotSignal_o, (i == 2) ? 1'b1 : 1'b0);
    end

    // Asynchronous reset in the middle of an SE0.
    do_reset();
    for (int i = 0; i < 3; i++) tick(PJ, 1'b1);
    for (int i = 0; i < 4; i++) tick(PK, 1'b1);
    for (int i = 0; i < 6; i++) tick(P0, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("arst_ls",  bus.lineState_o,   PJ);
    check("arst_got", bus.rxGotSignal_o, 1'b0);
    check("arst_eop", bus.eop_o,         1'b0);
    check("arst_err", bus.eopError_o,    1'b0);
    check("arst_usb", bus.usbReset_o,    1'b0);
    {bus.dataInP_i, bus.dataInN_i} = PJ;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_init();
    eop_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(PJ, 1'b1);
      eop_seen += int'(bus.eop_o) + int'(bus.eopError_o);
    end
    check("arst_no_pulse", 2'(eop_seen), 2'd0);

    // Randomized segments against the reference model.
    do_reset();
    begin
      int  cyc;
      bit  last_se0;
      cyc = 0;
      last_se0 = 1'b0;
      while (cyc < 3000) begin
        int         r;
        int         len;
        logic [1:0] sym;
        r = last_se0 ? int'($urandom_range(13, 0)) : int'($urandom_range(19, 0));
        if (r < 7) begin
          sym = PJ; len = int'($urandom_range(12, 1));
        end else if (r < 14) begin
          sym = PK; len = int'($urandom_range(12, 1));
        end else if (r < 18) begin
          sym = P0; len = int'($urandom_range(16, 1));
        end else if (r == 18) begin
          sym = P0; len = int'($urandom_range(170, 140));
        end else begin
          sym = P1; len = 1;
        end
        // Keep SE0 runs apart so filtered run lengths equal the generated ones.
        if (last_se0 && (len < 2)) len = 2;
        last_se0 = (sym == P0);
        for (int i = 0; i < len; i++) tick(sym, 1'b1);
        cyc += len;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
